md_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with HI/LO result registers.

---
 rtl/md_unit.sv | 120 ++++++++++++
 tb/tb_md_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Results are computed from latched operands on the final RUN edge; busy covers the whole latency.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdOp,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // op bit 0 clear selects the signed variant for both MULT and DIV
  logic               sgn;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic               a_neg, b_neg, div_by_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  assign sgn     = ~op_q[0];
  assign a_ext   = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
  assign b_ext   = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
  assign product = a_ext * b_ext;

  // Magnitude division; MIN/-1 falls out naturally as MIN with zero remainder
  assign a_neg       = sgn & a_q[WIDTH-1];
  assign b_neg       = sgn & b_q[WIDTH-1];
  assign a_mag       = a_neg ? -a_q : a_q;
  assign b_mag       = b_neg ? -b_q : b_q;
  assign div_by_zero = (b_q == '0);
  assign b_safe      = div_by_zero ? WIDTH'(1) : b_mag;
  assign q_mag       = a_mag / b_safe;
  assign r_mag       = a_mag % b_safe;
  assign quo         = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem         = a_neg ? -r_mag : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!mdOp[2]) begin
            a_d     = in1;
            b_d     = in2;
            op_d    = mdOp[1:0];
            cnt_d   = mdOp[1] ? DIV_LOAD : MULT_LOAD;
            state_d = RUN;
          end else if (mdOp == 3'b100) begin
            hi_d = in1;
          end else if (mdOp == 3'b101) begin
            lo_d = in1;
          end
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
          if (!op_q[1]) begin
            {hi_d, lo_d} = product;
          end else if (!div_by_zero) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign hiOut = hi_q;
  assign loOut = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: timing of busy, HI/LO results,
// MTHI/MTLO, ignored requests, divide-by-zero and asynchronous reset abort.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdOp = 3'b000;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        busy;
  logic [31:0] hiOut, loOut;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdOp(mdOp),
    .in1(in1), .in2(in2), .busy(busy), .hiOut(hiOut), .loOut(loOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mdOp = op; in1 = a; in2 = b;
    step();
    start = 1'b0; in1 = $urandom; in2 = $urandom;
  endtask

  // Issue a multi-cycle op, check hold during RUN, latency and final HI/LO
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] old_hi, old_lo;
    int cycles;
    old_hi = hiOut; old_lo = loOut;
    issue(op, a, b);
    chk({tag, " busy@accept"}, {31'd0, busy}, 32'd1);
    chk({tag, " hi hold"}, hiOut, old_hi);
    chk({tag, " lo hold"}, loOut, old_lo);
    cycles = 0;
    while (busy === 1'b1 && cycles < 64) begin
      step();
      cycles++;
    end
    chk({tag, " latency"}, 32'(cycles), 32'(lat));
    chk({tag, " hi"}, hiOut, ehi);
    chk({tag, " lo"}, loOut, elo);
    $display("%s: in1=%h in2=%h -> hi=%h lo=%h busy_cycles=%0d", tag, a, b, hiOut, loOut, cycles);
  endtask

  initial begin
    // Reset held from time 0; check outputs cleared before any edge
    #2;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hiOut, 32'd0);
    chk("reset lo", loOut, 32'd0);
    @(negedge clk); reset = 1'b0;
    step();

    // Mid-cycle asynchronous reset clears preset registers without an edge
    issue(OP_MTHI, 32'h55, 32'h0);
    issue(OP_MTLO, 32'h66, 32'h0);
    chk("preset hi", hiOut, 32'h55);
    chk("preset lo", loOut, 32'h66);
    @(negedge clk); reset = 1'b1; #1;
    chk("async rst hi", hiOut, 32'd0);
    chk("async rst lo", loOut, 32'd0);
    chk("async rst busy", {31'd0, busy}, 32'd0);
    $display("async reset: hi=%h lo=%h busy=%b", hiOut, loOut, busy);
    @(negedge clk); reset = 1'b0;
    step();

    run_op("MULT -2*3", OP_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("MULTU fffffffe*3", OP_MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
    run_op("MULT -5*-4", OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFC, 5, 32'h0, 32'd20);
    run_op("DIV -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("DIVU 7/2", OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);

    issue(OP_MTHI, 32'h11, 32'h0);
    chk("MTHI busy", {31'd0, busy}, 32'd0);
    issue(OP_MTLO, 32'h22, 32'h0);
    chk("MTLO busy", {31'd0, busy}, 32'd0);
    chk("MTHI hi", hiOut, 32'h11);
    chk("MTLO lo", loOut, 32'h22);
    $display("MTHI/MTLO: hi=%h lo=%h", hiOut, loOut);
    run_op("DIV 5/0", OP_DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22);
    run_op("DIVU 5/0", OP_DIVU, 32'd5, 32'd0, 10, 32'h11, 32'h22);
    run_op("DIV MIN/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

    // Reserved opcodes are ignored
    issue(3'b110, 32'hDEAD, 32'h1);
    chk("op110 busy", {31'd0, busy}, 32'd0);
    issue(3'b111, 32'hBEEF, 32'h1);
    chk("op111 busy", {31'd0, busy}, 32'd0);
    chk("op11x hi", hiOut, 32'h0);
    chk("op11x lo", loOut, 32'h80000000);
    $display("reserved ops: hi=%h lo=%h busy=%b", hiOut, loOut, busy);

    // start held through RUN: MTLO while busy and a request on the busy-fall edge are dropped
    start = 1'b1; mdOp = OP_MULT; in1 = 32'd6; in2 = 32'd7;
    step();
    chk("held accept busy", {31'd0, busy}, 32'd1);
    mdOp = OP_MTLO; in1 = 32'hDEAD;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("held busy", {31'd0, busy}, 32'd1);
      chk("held lo hold", loOut, 32'h80000000);
    end
    mdOp = OP_MULTU; in1 = 32'd100; in2 = 32'd100;
    step();
    chk("held fall busy", {31'd0, busy}, 32'd0);
    chk("held lo", loOut, 32'd42);
    chk("held hi", hiOut, 32'd0);
    start = 1'b0;
    step();
    chk("fall-edge start ignored", {31'd0, busy}, 32'd0);
    chk("held lo after", loOut, 32'd42);
    $display("held start MULT 6*7: hi=%h lo=%h busy=%b", hiOut, loOut, busy);

    // Reset during DIV at its third busy cycle aborts; nothing written afterwards
    issue(OP_DIV, 32'd100, 32'd7);
    step();
    step();
    chk("pre-abort busy", {31'd0, busy}, 32'd1);
    @(negedge clk); reset = 1'b1; #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("abort busy later", {31'd0, busy}, 32'd0);
    chk("abort hi", hiOut, 32'd0);
    chk("abort lo", loOut, 32'd0);
    $display("reset abort DIV: hi=%h lo=%h busy=%b", hiOut, loOut, busy);

    issue(OP_MTHI, 32'hABCD, 32'h0);
    chk("MTHI abcd busy", {31'd0, busy}, 32'd0);
    chk("MTHI abcd hi", hiOut, 32'hABCD);
    chk("MTHI abcd lo", loOut, 32'd0);
    step();
    chk("MTHI abcd busy next", {31'd0, busy}, 32'd0);
    $display("MTHI abcd: hi=%h lo=%h busy=%b", hiOut, loOut, busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
